// File: rtl/noc_serial_transmitter_if.sv
// Node-port link between an injecting client and a router: the transmitter
// presents a flit with enable, the router answers in the same cycle with ack/rej.
interface noc_serial_transmitter_if #(
    parameter int FLIT_WIDTH = 10
);
    logic                  enable;
    logic [FLIT_WIDTH-1:0] flit;
    logic                  ack;
    logic                  rej;

    modport master (output enable, output flit, input ack, input rej);
    modport slave  (input enable, input flit, output ack, output rej);
endinterface

// File: rtl/noc_serial_transmitter.sv
// Flit format shared with the NoC, and the packet serialiser that sends one
// HEADER followed by DATA/TAIL flits, restarting from the header on reject.
package noc_serial_transmitter_pkg;
    localparam int FLIT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        FLIT_NONE   = 2'd0,
        FLIT_HEADER = 2'd1,
        FLIT_DATA   = 2'd2,
        FLIT_TAIL   = 2'd3
    } flit_type_t;

    typedef struct packed {
        logic [3:0] dest;
        logic [3:0] free;
    } flit_hdr_t;

    typedef struct packed {
        flit_type_t                 flit_type;
        logic [FLIT_DATA_WIDTH-1:0] payload;
    } flit_t;

    localparam int FLIT_WIDTH = $bits(flit_t);
endpackage

module noc_serial_transmitter
    import noc_serial_transmitter_pkg::*;
#(
    parameter int PACKET_BITS  = 16,
    parameter int PADDING_BITS = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  flit_hdr_t                                     hdr,
    input  logic [(PADDING_BITS > 0 ? PADDING_BITS : 1)-1:0] padding,
    input  logic [PACKET_BITS-1:0]                        packet,
    noc_serial_transmitter_if.master                      up,
    output logic                                          busy,
    output logic                                          done
);
    localparam int N_FLITS  = (PACKET_BITS + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
    localparam int CNT_W    = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam int EXT_BITS = N_FLITS * FLIT_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                     state, state_next;
    logic [CNT_W-1:0]           cnt, cnt_next;
    flit_hdr_t                  hdr_reg, hdr_in;
    logic [FLIT_DATA_WIDTH-1:0] payload_regs [N_FLITS];
    logic [EXT_BITS-1:0]        packet_ext;
    logic                       accept;
    logic                       is_tail;
    logic                       enable_out;
    flit_t                      flit_out;

    // The sideband overwrites the low bits of hdr.free; without it the header is taken as-is.
    generate
        if (PADDING_BITS > 0) begin : g_pad
            always_comb begin
                hdr_in = hdr;
                hdr_in.free[PADDING_BITS-1:0] = padding;
            end
        end else begin : g_nopad
            logic unused_padding;
            assign unused_padding = ^padding;
            assign hdr_in         = hdr;
        end
    endgenerate

    assign packet_ext = EXT_BITS'(packet);
    assign accept     = (state == IDLE) && start;
    assign is_tail    = (cnt == CNT_W'(N_FLITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_reg <= '0;
            for (int i = 0; i < N_FLITS; i++) begin
                payload_regs[i] <= '0;
            end
        end else if (accept) begin
            hdr_reg <= hdr_in;
            for (int i = 0; i < N_FLITS; i++) begin
                payload_regs[i] <= packet_ext[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs depend on state/cnt only; ack and rej steer just the next state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enable_out = 1'b0;
        flit_out   = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HEADER;
                    cnt_next   = '0;
                end
            end
            HEADER: begin
                enable_out         = 1'b1;
                flit_out.flit_type = FLIT_HEADER;
                flit_out.payload   = hdr_reg;
                if (up.rej) begin
                    cnt_next = '0;
                end else if (up.ack) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                enable_out         = 1'b1;
                flit_out.flit_type = is_tail ? FLIT_TAIL : FLIT_DATA;
                flit_out.payload   = payload_regs[cnt];
                if (up.rej) begin
                    state_next = HEADER;
                    cnt_next   = '0;
                end else if (up.ack) begin
                    if (is_tail) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign up.enable = enable_out;
    assign up.flit   = flit_out;
endmodule

// File: tb/tb_noc_serial_transmitter.sv
// Bench for noc_serial_transmitter: a cycle table for backpressure/reject/start-while-busy,
// directed single-flit and reset cases, then random packets against a flit-list model.
module tb_noc_serial_transmitter;
    import noc_serial_transmitter_pkg::*;

    localparam int PACKET_BITS = 2*FLIT_DATA_WIDTH + 4;
    localparam int N_FLITS     = (PACKET_BITS + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
    localparam logic [PACKET_BITS-1:0] PKT = 20'h30201;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   start_b;
    flit_hdr_t              hdr;
    logic [3:0]             padding;
    logic [PACKET_BITS-1:0] packet;
    logic [7:0]             packet_b;
    logic                   pad_b;
    logic                   busy, done, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic                   start;
        logic                   ack;
        logic                   rej;
        logic [PACKET_BITS-1:0] packet;
        logic                   en;
        flit_type_t             ft;
        logic [7:0]             pl;
        logic                   busy;
        logic                   done;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    always #5 clk = ~clk;

    noc_serial_transmitter_if #(.FLIT_WIDTH(FLIT_WIDTH)) up_a ();
    noc_serial_transmitter_if #(.FLIT_WIDTH(FLIT_WIDTH)) up_b ();

    noc_serial_transmitter #(.PACKET_BITS(PACKET_BITS), .PADDING_BITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .hdr     (hdr),
        .padding (padding),
        .packet  (packet),
        .up      (up_a.master),
        .busy    (busy),
        .done    (done)
    );

    noc_serial_transmitter #(.PACKET_BITS(FLIT_DATA_WIDTH), .PADDING_BITS(0)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_b),
        .hdr     (hdr),
        .padding (pad_b),
        .packet  (packet_b),
        .up      (up_b.master),
        .busy    (busy_b),
        .done    (done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r, input logic [PACKET_BITS-1:0] p);
        start    = s;
        up_a.ack = a;
        up_a.rej = r;
        packet   = p;
    endtask

    function automatic void add_vec(logic s, logic a, logic r, logic [PACKET_BITS-1:0] p,
                                    logic en, flit_type_t ft, logic [7:0] pl, logic b, logic d);
        vec_t v;
        v.start = s; v.ack = a; v.rej = r; v.packet = p;
        v.en = en; v.ft = ft; v.pl = pl; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    // Expected packet on the wire: header with padding in free, then LSB-first byte slices.
    function automatic void build_expected(flit_hdr_t h, logic [3:0] pd, logic [PACKET_BITS-1:0] p);
        logic [31:0] v;
        flit_type_t  t;
        exp_q.delete();
        t = FLIT_HEADER;
        exp_q.push_back({t, h.dest, pd});
        v = 32'(p);
        for (int i = 0; i < N_FLITS; i++) begin
            t = (i == N_FLITS - 1) ? FLIT_TAIL : FLIT_DATA;
            exp_q.push_back({t, v[7:0]});
            v = v >> FLIT_DATA_WIDTH;
        end
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       seen_done;
        logic       prev_hold;
        logic [9:0] prev_flit;
        logic [9:0] cur;
        logic [9:0] exp_flit;
        int         guard;

        rst_n    = 1'b0;
        start    = 1'b0;
        start_b  = 1'b0;
        hdr      = '{dest: 4'h6, free: 4'h3};
        padding  = 4'h9;
        packet   = PKT;
        packet_b = 8'hA5;
        pad_b    = 1'b0;
        up_a.ack = 1'b0;
        up_a.rej = 1'b0;
        up_b.ack = 1'b1;
        up_b.rej = 1'b0;

        tick();
        tick();
        checkOutput("reset_enable", 32'(up_a.enable), 32'd0);
        checkOutput("reset_flit",   32'(up_a.flit),   32'd0);
        checkOutput("reset_busy",   32'(busy),        32'd0);
        checkOutput("reset_done",   32'(done),        32'd0);
        rst_n = 1'b1;
        tick();

        // Single-flit packet on the narrow instance
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checkOutput("single_c1_flit", 32'(up_b.flit), 32'({FLIT_HEADER, 8'h63}));
        checkOutput("single_c1_busy", 32'(busy_b),    32'd1);
        tick();
        checkOutput("single_c2_flit", 32'(up_b.flit), 32'({FLIT_TAIL, 8'hA5}));
        checkOutput("single_c2_busy", 32'(busy_b),    32'd1);
        tick();
        checkOutput("single_c3_done", 32'({busy_b, done_b, up_b.enable}), 32'b110);
        tick();
        checkOutput("single_c4_idle", 32'({busy_b, done_b, up_b.enable}), 32'b000);

        // Backpressure, start-while-busy, then reject-with-ack and full retransmission
        add_vec(1,0,0,PKT,   0,FLIT_NONE,  8'h00,0,0);
        add_vec(0,0,0,PKT,   1,FLIT_HEADER,8'h69,1,0);
        add_vec(0,0,0,PKT,   1,FLIT_HEADER,8'h69,1,0);
        add_vec(0,0,0,PKT,   1,FLIT_HEADER,8'h69,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_HEADER,8'h69,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_DATA,  8'h01,1,0);
        add_vec(1,0,0,20'h0, 1,FLIT_DATA,  8'h02,1,0);
        add_vec(0,0,0,PKT,   1,FLIT_DATA,  8'h02,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_DATA,  8'h02,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_TAIL,  8'h03,1,0);
        add_vec(0,0,0,PKT,   0,FLIT_NONE,  8'h00,1,1);
        add_vec(1,1,0,PKT,   0,FLIT_NONE,  8'h00,0,0);
        add_vec(0,1,0,PKT,   1,FLIT_HEADER,8'h69,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_DATA,  8'h01,1,0);
        add_vec(0,1,1,PKT,   1,FLIT_DATA,  8'h02,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_HEADER,8'h69,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_DATA,  8'h01,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_DATA,  8'h02,1,0);
        add_vec(0,1,0,PKT,   1,FLIT_TAIL,  8'h03,1,0);
        add_vec(0,0,0,PKT,   0,FLIT_NONE,  8'h00,1,1);
        add_vec(0,0,0,PKT,   0,FLIT_NONE,  8'h00,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].ack, vecs[i].rej, vecs[i].packet);
            exp_flit = vecs[i].en ? {vecs[i].ft, vecs[i].pl} : 10'd0;
            checkOutput($sformatf("row%0d_enable", i), 32'(up_a.enable), 32'(vecs[i].en));
            checkOutput($sformatf("row%0d_flit", i),   32'(up_a.flit),   32'(exp_flit));
            checkOutput($sformatf("row%0d_busy", i),   32'(busy),        32'(vecs[i].busy));
            checkOutput($sformatf("row%0d_done", i),   32'(done),        32'(vecs[i].done));
            tick();
        end

        // Reset asserted mid-packet takes effect without a clock edge
        applyStimulus(1, 1, 0, PKT);
        tick();
        start = 1'b0;
        tick();
        checkOutput("pre_reset_flit", 32'(up_a.flit), 32'({FLIT_DATA, 8'h01}));
        up_a.ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_enable", 32'(up_a.enable), 32'd0);
        checkOutput("async_reset_busy",   32'(busy),        32'd0);
        checkOutput("async_reset_flit",   32'(up_a.flit),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 1, 0, PKT);
        tick();
        start = 1'b0;
        checkOutput("post_reset_header", 32'(up_a.flit), 32'({FLIT_HEADER, 8'h69}));
        guard = 0;
        while (!done && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("post_reset_done", 32'(done), 32'd1);
        tick();

        // Random packets with random ack/rej and spurious starts while busy
        for (int n = 0; n < 40; n++) begin
            checkOutput($sformatf("pkt%0d_idle", n), 32'({busy, done}), 32'd0);
            hdr     = 8'($urandom);
            padding = 4'($urandom);
            packet  = PACKET_BITS'($urandom);
            build_expected(hdr, padding, packet);
            got_q.delete();
            applyStimulus(1, 0, 0, packet);
            tick();
            start     = 1'b0;
            seen_done = 1'b0;
            prev_hold = 1'b0;
            prev_flit = '0;
            for (int c = 0; c < 300 && !seen_done; c++) begin
                up_a.ack = ($urandom_range(0, 99) < 70);
                up_a.rej = ($urandom_range(0, 99) < 4);
                if ($urandom_range(0, 9) == 0) begin
                    start   = 1'b1;
                    packet  = PACKET_BITS'($urandom);
                    hdr     = 8'($urandom);
                    padding = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
                cur = up_a.flit;
                if (prev_hold) begin
                    checkOutput($sformatf("pkt%0d_hold", n), 32'(cur), 32'(prev_flit));
                end
                if (up_a.enable && up_a.rej) begin
                    got_q.delete();
                end else if (up_a.enable && up_a.ack) begin
                    got_q.push_back(cur);
                end
                if (done) begin
                    seen_done = 1'b1;
                end
                prev_hold = up_a.enable && !up_a.ack && !up_a.rej;
                prev_flit = cur;
                tick();
            end
            start = 1'b0;
            checkOutput($sformatf("pkt%0d_done_seen", n), 32'(seen_done), 32'd1);
            checkOutput($sformatf("pkt%0d_len", n), 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) begin
                cur = (i < got_q.size()) ? got_q[i] : 10'h3FF;
                checkOutput($sformatf("pkt%0d_flit%0d", n, i), 32'(cur), 32'(exp_q[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
